ahb_slave_pipeline: RTL and testbench
=====================================

Name: ahb_slave_pipeline

Overview:
- Upstream AHB-side front end of the AHB-to-APB bridge.
- Decodes AHB address-phase signals into `valid` and `tempsel`, and pipelines address, data and write-control into the `haddr1`/`haddr2`/`hwdata1`/`hwdata2`/`hwritereg` registers consumed by the APB FSM controller.
- Generates the two-cycle AHB ERROR response for unmapped addresses.
- Tracks burst beats to flag protocol violations.

Parameters:
- `SLV0_BASE`, 32'h8000_0000, base of APB slave 0 region (64 MB)
- `SLV1_BASE`, 32'h8400_0000, base of APB slave 1 region (64 MB)
- `SLV2_BASE`, 32'h8800_0000, base of APB slave 2 region (64 MB)
- `REGION_BITS`, 26, log2 of region size; hit = `haddr[31:REGION_BITS]` equals `BASE[31:REGION_BITS]`

Ports:
- `hclk`  in  1  bridge clock, rising edge
- `hreset`  in  1  synchronous reset, active-high
- `hwrite`  in  1  AHB write/read
- `hreadyin`  in  1  AHB HREADY from the bus (previous transfer completing)
- `htrans`  in  2  AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- `hburst`  in  3  AHB burst type
- `hsize`  in  3  AHB transfer size
- `haddr`  in  32  AHB address
- `hwdata`  in  32  AHB write data
- `burst_err_clr`  in  1  clears the sticky `burst_err`
- `valid`  out  1  combinational: accepted mapped transfer this cycle
- `tempsel`  out  3  combinational one-hot slave select (001/010/100, 000 = unmapped)
- `haddr1`  out  32  `haddr` delayed 1 accepted cycle
- `haddr2`  out  32  `haddr` delayed 2 accepted cycles
- `hwdata1`  out  32  `hwdata` delayed 1
- `hwdata2`  out  32  `hwdata` delayed 2
- `hwritereg`  out  1  `hwrite` delayed 1
- `hresp`  out  2  AHB response: 00 OKAY, 01 ERROR
- `hready_err`  out  1  slave HREADY contribution from the error path (1 when no error in progress)
- `beat_cnt`  out  5  beats accepted in the current burst
- `burst_err`  out  1  sticky protocol-violation flag

Behaviour:
- Reset (`hreset` high at a posedge) applies the following; reset mid-burst or mid-error aborts immediately:
  - All pipeline registers, `hwritereg`, `beat_cnt`, `burst_err` and the expected-address register go to 0.
  - `hresp` goes to 00, `hready_err` to 1, and the error FSM to E_IDLE.
- Accept condition: `acc = hreadyin & htrans[1] & (err_state != E_ERR1)`.
- `valid = acc & (tempsel != 0)`; purely combinational, zero latency.
- `tempsel` decodes `haddr`; overlapping bases give priority slave0 > slave1 > slave2.
- Pipeline, at each posedge with `hreadyin` = 1:
  - `haddr1 <= haddr`, `haddr2 <= haddr1`
  - `hwdata1 <= hwdata`, `hwdata2 <= hwdata1`
  - `hwritereg <= hwrite`
  - With `hreadyin` = 0, all pipeline registers hold. The pipeline shifts on IDLE/BUSY cycles too; only `hreadyin` gates it.
- Error FSM, states E_IDLE, E_ERR1, E_ERR2:
  - E_IDLE: `hresp` = 00, `hready_err` = 1. Moves to E_ERR1 when `acc & (tempsel == 0)`.
  - E_ERR1: `hresp` = 01, `hready_err` = 0. Always moves to E_ERR2. `valid` is forced 0.
  - E_ERR2: `hresp` = 01, `hready_err` = 1. Always moves to E_IDLE. A transfer presented here is accepted normally; if it is also unmapped, the next state is E_ERR1 again.
  - `hresp` and `hready_err` are registered (Moore) outputs.
- Burst tracker (updates only on `valid`):
  - Length from `hburst`: SINGLE = 1, INCR = 0 (unbounded), INCR4/WRAP4 = 4, INCR8/WRAP8 = 8, INCR16/WRAP16 = 16.
  - NONSEQ: `beat_cnt <= 1`; latch length; `exp_addr <= haddr + (1 << hsize)`. `hsize` > 3'b010 sets `burst_err`.
  - SEQ sets `burst_err` when any of the following holds:
    - `beat_cnt` == 0 (SEQ with no preceding NONSEQ);
    - `haddr != exp_addr`;
    - length != 0 and `beat_cnt` == length (overrun).
  - SEQ otherwise: `beat_cnt` increments, saturating at 31, and `exp_addr` advances by `1 << hsize`.
  - BUSY holds all tracker state. IDLE with `hreadyin` = 1 clears `beat_cnt`. An unmapped transfer clears `beat_cnt`.
  - `burst_err` is cleared by `burst_err_clr`; a set condition in the same cycle wins.
- Address arithmetic is 32-bit and wraps modulo 2^32.

Optional Feature:
- Macro: `AHB_WRAP_BURST_EN`.
- Defined: for WRAP4/8/16, with `mask = length * (1 << hsize) - 1`, `exp_addr = (cur & ~mask) | ((cur + (1 << hsize)) & mask)`.
- Undefined: a NONSEQ with WRAPx sets `burst_err`, and subsequent beats are checked as INCRx.

Test Plan:
- Reset: assert `hreset` for 2 cycles mid-transfer -> all pipeline outputs 0, `hresp` = 00, `hready_err` = 1, `beat_cnt` = 0, `burst_err` = 0.
- Single write: NONSEQ write to 32'h8000_0010 with `hreadyin` = 1, next cycle `hwdata` = 32'hA5A5_0001 -> `valid` = 1 and `tempsel` = 001 same cycle; `haddr1` = 32'h8000_0010 after 1 clock, `haddr2` after 2; `hwdata1` = 32'hA5A5_0001; `hwritereg` = 1.
- Unmapped: NONSEQ to 32'h9000_0000 -> `valid` = 0, `tempsel` = 000; next cycle `hresp` = 01 with `hready_err` = 0; following cycle `hresp` = 01 with `hready_err` = 1; then `hresp` = 00.
- INCR4 with stall: NONSEQ 32'h8400_0000 then SEQ 04/08/0C, `hsize` = 010, one BUSY inserted and `hreadyin` low for 1 cycle -> `beat_cnt` 1..4, pipeline holds during the stall, `burst_err` stays 0.
- Violation: INCR4 with SEQ address 32'h8400_0008 after beat 1 -> `burst_err` = 1 and stays set; pulse `burst_err_clr` -> 0.
- Wrap (macro defined): WRAP4 starting at 32'h8800_0008 -> expected beats 08, 0C, 00, 04 accepted with no error. Macro undefined: `burst_err` = 1 on the NONSEQ.

Source files
------------

// File: rtl/ahb_slave_pipeline.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : ahb_slave_pipeline                                          |
// | Desc     : AHB-side front end of the AHB-to-APB bridge: address decode, |
// |            address/data pipeline, ERROR response and burst checking.    |
// |            Define AHB_WRAP_BURST_EN to enable WRAP4/8/16 address checks.|
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module ahb_slave_pipeline #(
    parameter logic [31:0] SLV0_BASE   = 32'h8000_0000,
    parameter logic [31:0] SLV1_BASE   = 32'h8400_0000,
    parameter logic [31:0] SLV2_BASE   = 32'h8800_0000,
    parameter int          REGION_BITS = 26
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hwrite,
    input  logic        hreadyin,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hburst,
    input  logic [2:0]  hsize,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    input  logic        burst_err_clr,
    output logic        valid,
    output logic [2:0]  tempsel,
    output logic [31:0] haddr1,
    output logic [31:0] haddr2,
    output logic [31:0] hwdata1,
    output logic [31:0] hwdata2,
    output logic        hwritereg,
    output logic [1:0]  hresp,
    output logic        hready_err,
    output logic [4:0]  beat_cnt,
    output logic        burst_err
);

    typedef enum logic [1:0] {
        E_IDLE = 2'd0,
        E_ERR1 = 2'd1,
        E_ERR2 = 2'd2
    } err_state_e;

    localparam logic [1:0] c_TRANS_IDLE = 2'b00;

    err_state_e  err_state_q, err_state_d;
    logic [31:0] haddr1_q, haddr2_q, hwdata1_q, hwdata2_q;
    logic        hwritereg_q;
    logic [1:0]  hresp_q;
    logic        hready_err_q;
    logic [4:0]  beat_cnt_q, beat_cnt_d;
    logic [4:0]  len_q, len_d;
    logic [31:0] exp_addr_q, exp_addr_d;
    logic        burst_err_q, burst_err_d;

    logic        w_hit0, w_hit1, w_hit2;
    logic [2:0]  w_tempsel;
    logic        w_acc, w_unmapped, w_valid;
    logic [4:0]  w_len;
    logic        w_is_wrap;
    logic [31:0] w_step, w_incr, w_next;
    logic        w_set;

    // ------------------------------------------------------------------
    // Address decode and accept
    // ------------------------------------------------------------------
    assign w_hit0 = (haddr[31:REGION_BITS] == SLV0_BASE[31:REGION_BITS]);
    assign w_hit1 = (haddr[31:REGION_BITS] == SLV1_BASE[31:REGION_BITS]);
    assign w_hit2 = (haddr[31:REGION_BITS] == SLV2_BASE[31:REGION_BITS]);

    always_comb begin
        w_tempsel = 3'b000;
        if (w_hit0)      w_tempsel = 3'b001;
        else if (w_hit1) w_tempsel = 3'b010;
        else if (w_hit2) w_tempsel = 3'b100;
    end

    assign w_acc      = hreadyin & htrans[1] & (err_state_q != E_ERR1);
    assign w_unmapped = (w_tempsel == 3'b000);
    assign w_valid    = w_acc & ~w_unmapped;

    // ------------------------------------------------------------------
    // Address / data pipeline, gated only by hreadyin
    // ------------------------------------------------------------------
    always_ff @(posedge hclk) begin
        if (hreset) begin
            haddr1_q    <= 32'd0;
            haddr2_q    <= 32'd0;
            hwdata1_q   <= 32'd0;
            hwdata2_q   <= 32'd0;
            hwritereg_q <= 1'b0;
        end else if (hreadyin) begin
            haddr1_q    <= haddr;
            haddr2_q    <= haddr1_q;
            hwdata1_q   <= hwdata;
            hwdata2_q   <= hwdata1_q;
            hwritereg_q <= hwrite;
        end
    end

    // ------------------------------------------------------------------
    // Two-cycle ERROR response FSM
    // ------------------------------------------------------------------
    always_ff @(posedge hclk) begin
        if (hreset) begin
            err_state_q  <= E_IDLE;
            hresp_q      <= 2'b00;
            hready_err_q <= 1'b1;
        end else begin
            err_state_q  <= err_state_d;
            hresp_q      <= (err_state_d == E_IDLE) ? 2'b00 : 2'b01;
            hready_err_q <= (err_state_d != E_ERR1);
        end
    end

    always_comb begin
        err_state_d = err_state_q;
        case (err_state_q)
            E_IDLE:  if (w_acc & w_unmapped) err_state_d = E_ERR1;
            E_ERR1:  err_state_d = E_ERR2;
            E_ERR2:  err_state_d = (w_acc & w_unmapped) ? E_ERR1 : E_IDLE;
            default: err_state_d = E_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Burst tracker
    // ------------------------------------------------------------------
    always_comb begin
        w_len     = 5'd0;
        w_is_wrap = 1'b0;
        case (hburst)
            3'b000:  w_len = 5'd1;
            3'b001:  w_len = 5'd0;
            3'b010:  begin w_len = 5'd4;  w_is_wrap = 1'b1; end
            3'b011:  w_len = 5'd4;
            3'b100:  begin w_len = 5'd8;  w_is_wrap = 1'b1; end
            3'b101:  w_len = 5'd8;
            3'b110:  begin w_len = 5'd16; w_is_wrap = 1'b1; end
            default: w_len = 5'd16;
        endcase
    end

    assign w_step = 32'd1 << hsize;
    assign w_incr = haddr + w_step;

`ifdef AHB_WRAP_BURST_EN
    logic        wrap_q, wrap_d;
    logic [4:0]  w_adv_len;
    logic        w_adv_wrap;
    logic [31:0] w_mask;

    // A successful SEQ has haddr == exp_addr, so haddr is the current beat either way
    assign w_adv_len  = htrans[0] ? len_q  : w_len;
    assign w_adv_wrap = htrans[0] ? wrap_q : w_is_wrap;
    assign w_mask     = ({27'd0, w_adv_len} << hsize) - 32'd1;
    assign w_next     = w_adv_wrap ? ((haddr & ~w_mask) | (w_incr & w_mask)) : w_incr;

    always_ff @(posedge hclk) begin
        if (hreset) wrap_q <= 1'b0;
        else        wrap_q <= wrap_d;
    end
`else
    assign w_next = w_incr;
`endif

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        exp_addr_d = exp_addr_q;
        w_set      = 1'b0;
`ifdef AHB_WRAP_BURST_EN
        wrap_d     = wrap_q;
`endif
        if (w_valid) begin
            if (!htrans[0]) begin
                beat_cnt_d = 5'd1;
                len_d      = w_len;
                exp_addr_d = w_next;
                if (hsize > 3'b010) w_set = 1'b1;
`ifdef AHB_WRAP_BURST_EN
                wrap_d     = w_is_wrap;
`else
                if (w_is_wrap) w_set = 1'b1;
`endif
            end else if ((beat_cnt_q == 5'd0) || (haddr != exp_addr_q) ||
                         ((len_q != 5'd0) && (beat_cnt_q == len_q))) begin
                w_set = 1'b1;
            end else begin
                if (beat_cnt_q != 5'd31) beat_cnt_d = beat_cnt_q + 5'd1;
                exp_addr_d = w_next;
            end
        end else if (w_acc) begin
            beat_cnt_d = 5'd0;
        end else if (hreadyin && (htrans == c_TRANS_IDLE)) begin
            beat_cnt_d = 5'd0;
        end

        if (w_set)              burst_err_d = 1'b1;
        else if (burst_err_clr) burst_err_d = 1'b0;
        else                    burst_err_d = burst_err_q;
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            beat_cnt_q  <= 5'd0;
            len_q       <= 5'd0;
            exp_addr_q  <= 32'd0;
            burst_err_q <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            len_q       <= len_d;
            exp_addr_q  <= exp_addr_d;
            burst_err_q <= burst_err_d;
        end
    end

    assign valid      = w_valid;
    assign tempsel    = w_tempsel;
    assign haddr1     = haddr1_q;
    assign haddr2     = haddr2_q;
    assign hwdata1    = hwdata1_q;
    assign hwdata2    = hwdata2_q;
    assign hwritereg  = hwritereg_q;
    assign hresp      = hresp_q;
    assign hready_err = hready_err_q;
    assign beat_cnt   = beat_cnt_q;
    assign burst_err  = burst_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_pipeline.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_ahb_slave_pipeline                                       |
// | Desc     : Scoreboard bench for ahb_slave_pipeline with a reference     |
// |            model; honours AHB_WRAP_BURST_EN like the design.            |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module tb_ahb_slave_pipeline;

    localparam logic [1:0] c_ID = 2'b00;
    localparam logic [1:0] c_BZ = 2'b01;
    localparam logic [1:0] c_NS = 2'b10;
    localparam logic [1:0] c_SQ = 2'b11;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        hwrite = 1'b0;
    logic        hreadyin = 1'b1;
    logic [1:0]  htrans = 2'b00;
    logic [2:0]  hburst = 3'b000;
    logic [2:0]  hsize = 3'b000;
    logic [31:0] haddr = 32'd0;
    logic [31:0] hwdata = 32'd0;
    logic        burst_err_clr = 1'b0;

    logic        valid;
    logic [2:0]  tempsel;
    logic [31:0] haddr1, haddr2, hwdata1, hwdata2;
    logic        hwritereg;
    logic [1:0]  hresp;
    logic        hready_err;
    logic [4:0]  beat_cnt;
    logic        burst_err;

    ahb_slave_pipeline dut (
        .hclk          (hclk),
        .hreset        (hreset),
        .hwrite        (hwrite),
        .hreadyin      (hreadyin),
        .htrans        (htrans),
        .hburst        (hburst),
        .hsize         (hsize),
        .haddr         (haddr),
        .hwdata        (hwdata),
        .burst_err_clr (burst_err_clr),
        .valid         (valid),
        .tempsel       (tempsel),
        .haddr1        (haddr1),
        .haddr2        (haddr2),
        .hwdata1       (hwdata1),
        .hwdata2       (hwdata2),
        .hwritereg     (hwritereg),
        .hresp         (hresp),
        .hready_err    (hready_err),
        .beat_cnt      (beat_cnt),
        .burst_err     (burst_err)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        int          cyc;
        logic        valid;
        logic [2:0]  tsel;
        logic [31:0] a1, a2, d1, d2;
        logic        wr;
        logic [1:0]  resp;
        logic        rdy;
        logic [4:0]  beats;
        logic        berr;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc_no = 0;

    // Reference model state
    logic [31:0] m_a1, m_a2, m_d1, m_d2, m_start, m_size;
    logic        m_wr, m_berr, m_wrap;
    int          m_err_left, m_beats, m_len, m_idx;

    function automatic logic [2:0] ref_sel(input logic [31:0] a);
        logic [31:0] off;
        if (a < 32'h8000_0000 || a >= 32'h8C00_0000) return 3'b000;
        off = (a - 32'h8000_0000) / 32'h0400_0000;
        return 3'(1 << off);
    endfunction

    function automatic int ref_len(input logic [2:0] b);
        if (b == 3'd0) return 1;
        if (b == 3'd1) return 0;
        return 2 ** (2 + (int'(b) - 2) / 2);
    endfunction

    function automatic logic ref_is_wrap(input logic [2:0] b);
        return (b >= 3'd2) && !b[0];
    endfunction

    function automatic logic [31:0] ref_addr(input int n);
        logic [31:0] off, span, lo;
        off = 32'(n) * m_size;
        if (m_wrap) begin
            span = 32'(m_len) * m_size;
            lo   = m_start % span;
            return (m_start - lo) + ((lo + off) % span);
        end
        return m_start + off;
    endfunction

    task automatic model_step();
        logic       acc, set;
        logic [2:0] s;
        if (hreset) begin
            m_a1 = 0; m_a2 = 0; m_d1 = 0; m_d2 = 0; m_wr = 0;
            m_err_left = 0; m_beats = 0; m_berr = 0;
            m_len = 0; m_idx = 0; m_start = 0; m_size = 0; m_wrap = 0;
        end else begin
            s   = ref_sel(haddr);
            acc = hreadyin && htrans[1] && (m_err_left != 2);
            set = 1'b0;
            if (hreadyin) begin
                m_a2 = m_a1; m_a1 = haddr; m_d2 = m_d1; m_d1 = hwdata; m_wr = hwrite;
            end
            if (acc && s != 3'b000) begin
                if (htrans == c_NS) begin
                    m_beats = 1; m_idx = 1; m_len = ref_len(hburst);
                    m_start = haddr; m_size = 32'd1 << hsize; m_wrap = 1'b0;
                    if (hsize > 3'd2) set = 1'b1;
                    if (ref_is_wrap(hburst)) begin
`ifdef AHB_WRAP_BURST_EN
                        m_wrap = 1'b1;
`else
                        set = 1'b1;
`endif
                    end
                end else if (m_beats == 0 || haddr != ref_addr(m_idx) ||
                             (m_len != 0 && m_beats == m_len)) begin
                    set = 1'b1;
                end else begin
                    m_idx++;
                    if (m_beats < 31) m_beats++;
                end
            end else if (acc) begin
                m_beats = 0;
            end else if (hreadyin && htrans == c_ID) begin
                m_beats = 0;
            end
            if (set) m_berr = 1'b1;
            else if (burst_err_clr) m_berr = 1'b0;
            if (acc && s == 3'b000) m_err_left = 2;
            else if (m_err_left > 0) m_err_left--;
        end
    endtask

    task automatic push_exp();
        exp_t       e;
        logic       acc;
        logic [2:0] s;
        s       = ref_sel(haddr);
        acc     = hreadyin && htrans[1] && (m_err_left != 2);
        e.cyc   = cyc_no;
        e.valid = acc && (s != 3'b000);
        e.tsel  = s;
        e.a1 = m_a1; e.a2 = m_a2; e.d1 = m_d1; e.d2 = m_d2; e.wr = m_wr;
        e.resp  = (m_err_left != 0) ? 2'b01 : 2'b00;
        e.rdy   = (m_err_left != 2);
        e.beats = 5'(m_beats);
        e.berr  = m_berr;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] bu,
                         input logic [2:0] sz, input logic wr, input logic rdy,
                         input logic clr, input logic rst, input logic [31:0] wd);
        @(posedge hclk);
        model_step();
        #1;
        cyc_no++;
        hreset = rst; htrans = tr; haddr = a; hburst = bu; hsize = sz;
        hwrite = wr; hreadyin = rdy; burst_err_clr = clr; hwdata = wd;
        push_exp();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(c_ID, 32'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, $urandom);
    endtask

    task automatic chk(input string nm, input int c, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, got, want);
        end
    endtask

    // Monitor: every cycle the DUT presents a full set of outputs
    exp_t mon_e;
    initial forever begin
        @(negedge hclk);
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("valid",      mon_e.cyc, 32'(valid),      32'(mon_e.valid));
            chk("tempsel",    mon_e.cyc, 32'(tempsel),    32'(mon_e.tsel));
            chk("haddr1",     mon_e.cyc, haddr1,          mon_e.a1);
            chk("haddr2",     mon_e.cyc, haddr2,          mon_e.a2);
            chk("hwdata1",    mon_e.cyc, hwdata1,         mon_e.d1);
            chk("hwdata2",    mon_e.cyc, hwdata2,         mon_e.d2);
            chk("hwritereg",  mon_e.cyc, 32'(hwritereg),  32'(mon_e.wr));
            chk("hresp",      mon_e.cyc, 32'(hresp),      32'(mon_e.resp));
            chk("hready_err", mon_e.cyc, 32'(hready_err), 32'(mon_e.rdy));
            chk("beat_cnt",   mon_e.cyc, 32'(beat_cnt),   32'(mon_e.beats));
            chk("burst_err",  mon_e.cyc, 32'(burst_err),  32'(mon_e.berr));
        end
    end

    task automatic random_burst();
        logic [31:0] base, start, a, span;
        logic [2:0]  bu, sz;
        logic [1:0]  tr;
        logic        wr;
        int          r, len, nb;
        r = $urandom_range(0, 9);
        if (r < 9) base = 32'h8000_0000 + (32'(r % 3) << 26);
        else begin
            r = $urandom_range(0, 2);
            base = (r == 0) ? 32'h9000_0000 : (r == 1) ? 32'h7FFF_F000 : 32'h8C00_0000;
        end
        sz    = ($urandom_range(0, 19) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        bu    = 3'($urandom_range(0, 7));
        len   = ref_len(bu);
        if (len == 0) len = $urandom_range(1, 6);
        nb    = len + (($urandom_range(0, 9) == 0) ? 1 : 0);
        start = base + (32'($urandom_range(0, 255)) << sz);
        span  = 32'(len) << sz;
        wr    = 1'($urandom_range(0, 1));
        for (int i = 0; i < nb; i++) begin
            if (ref_is_wrap(bu)) a = (start & ~(span - 1)) | ((start + (32'(i) << sz)) & (span - 1));
            else                 a = start + (32'(i) << sz);
            if ($urandom_range(0, 19) == 0) a = a ^ 32'h10;
            tr = c_SQ;
            if (i == 0) begin
                if ($urandom_range(0, 29) == 0) idle(1);
                else tr = c_NS;
            end
            if (i > 0 && $urandom_range(0, 9) == 0)
                drive(c_BZ, a, bu, sz, wr, 1'b1, 1'b0, 1'b0, $urandom);
            if ($urandom_range(0, 7) == 0)
                drive(tr, a, bu, sz, wr, 1'b0, 1'b0, 1'b0, $urandom);
            drive(tr, a, bu, sz, wr, 1'b1, 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 199) == 0), $urandom);
        end
        repeat ($urandom_range(0, 2))
            drive(c_ID, 32'd0, 3'd0, 3'd0, 1'b0, 1'($urandom_range(0, 3) != 0), 1'b0, 1'b0, $urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc_no);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held two cycles
        drive(c_ID, 32'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
        drive(c_ID, 32'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
        idle(1);
        // Single write with data phase
        drive(c_NS, 32'h8000_0010, 3'd0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        drive(c_ID, 32'h0, 3'd0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA5A5_0001);
        idle(2);
        // Unmapped -> two-cycle ERROR
        drive(c_NS, 32'h9000_0000, 3'd0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(3);
        // INCR4 with BUSY and a wait state
        drive(c_NS, 32'h8400_0000, 3'd3, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h11);
        drive(c_SQ, 32'h8400_0004, 3'd3, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h22);
        drive(c_BZ, 32'h8400_0008, 3'd3, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h33);
        drive(c_SQ, 32'h8400_0008, 3'd3, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h44);
        drive(c_SQ, 32'h8400_0008, 3'd3, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h55);
        drive(c_SQ, 32'h8400_000C, 3'd3, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h66);
        idle(1);
        // Address skip violation, then clear
        drive(c_NS, 32'h8400_0000, 3'd3, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        drive(c_SQ, 32'h8400_0008, 3'd3, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(2);
        drive(c_ID, 32'h0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        idle(1);
        // WRAP4 crossing the 16-byte boundary
        drive(c_NS, 32'h8800_0008, 3'd2, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        drive(c_SQ, 32'h8800_000C, 3'd2, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1);
        drive(c_SQ, 32'h8800_0000, 3'd2, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h2);
        drive(c_SQ, 32'h8800_0004, 3'd2, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h3);
        idle(1);
        drive(c_ID, 32'h0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        // Reset mid-burst and mid-error
        drive(c_NS, 32'h8000_0100, 3'd5, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h7);
        drive(c_SQ, 32'h8000_0104, 3'd5, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8);
        drive(c_SQ, 32'h8000_0104, 3'd5, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'h9);
        drive(c_SQ, 32'h8000_0108, 3'd5, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA);
        drive(c_NS, 32'h8C00_0000, 3'd0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        drive(c_ID, 32'h0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        idle(2);

        for (int b = 0; b < 400; b++) random_burst();
        idle(3);

        @(negedge hclk);
        #1;
        for (int k = 0; k < 5 && sb.size() != 0; k++) begin
            @(negedge hclk);
            #1;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain cyc=%0d got=%0d want=0", cyc_no, sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
